// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA issue sequencer.
// Covers FSM states, instruction field positions and flag bit positions.
package ula_pkg;

  localparam int unsigned INSN_W = 16;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_IMM,
    EXEC,
    WB,
    HALT
  } state_t;

  localparam logic [1:0]      FMT_ARIT = 2'b10;
  localparam logic [OP_W-1:0] OP_HALT  = 8'hFF;

  localparam int unsigned FL_O = 3;
  localparam int unsigned FL_C = 2;
  localparam int unsigned FL_S = 1;
  localparam int unsigned FL_Z = 0;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 8;
  localparam int unsigned RD_MSB = 7;
  localparam int unsigned RD_LSB = 4;
  localparam int unsigned RB_MSB = 3;
  localparam int unsigned RB_LSB = 0;

  // Register-register ops carry fmt=10 in the top two bits of the OP byte.
  function automatic logic is_arit(input logic [OP_W-1:0] op);
    return op[OP_W-1:OP_W-2] == FMT_ARIT;
  endfunction

endpackage

// File: rtl/ula_fetch_if.sv
// Program-memory fetch port: req/valid handshake and the program counter.
// The address is the registered pc, so it cannot move while a request is open.
module ula_fetch_if
  import ula_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_go,
  input  logic              imem_valid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  output logic              word_ok,
  output logic [INSN_W-1:0] word
);

  logic            req_q;
  logic [PC_W-1:0] pc_q, pc_d;

  // Valid only counts while a request is open; stale responses fall through.
  assign word_ok   = req_q & imem_valid;
  assign word      = imem_rdata;
  assign imem_req  = req_q;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (word_ok) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      pc_q  <= PC_W'(RESET_PC);
    end else begin
      req_q <= fetch_go;
      pc_q  <= pc_d;
    end
  end

endmodule

// File: rtl/ula_issue_ctrl.sv
// Multicycle sequencer: fetch, read regfile, drive the ULA, write back and latch flags.
// Operands hold their last EXEC values so the ULA never sees a glitch between instructions.
module ula_issue_ctrl
  import ula_pkg::*;
#(
  parameter int unsigned BITS     = 16,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RF_AW    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [RF_AW-1:0]  rf_ra,
  output logic [RF_AW-1:0]  rf_rb,
  input  logic [BITS-1:0]   rf_da,
  input  logic [BITS-1:0]   rf_db,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_wa,
  output logic [BITS-1:0]   rf_wd,
  output logic [BITS-1:0]   ula_a,
  output logic [BITS-1:0]   ula_b,
  output logic [OP_W-1:0]   ula_op,
  input  logic [BITS-1:0]   ula_resu,
  input  logic              ula_o,
  input  logic              ula_c,
  input  logic              ula_s,
  input  logic              ula_z,
  output logic [FLAG_W-1:0] flags
);

  state_t              state_q, state_d;
  logic [INSN_W-1:0]   ir_q, ir_d;
  logic [BITS-1:0]     imm_q, imm_d, res_q, res_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [BITS-1:0]     a_hold_q, b_hold_q;
  logic [OP_W-1:0]     op_hold_q;
  logic                busy_q, halted_q, rf_we_q;
  logic                fetch_go, word_ok;
  logic [INSN_W-1:0]   word;
  logic [OP_W-1:0]     ir_op, word_op;
  logic [BITS-1:0]     exec_b;
  logic                in_exec;

  ula_fetch_if #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_go   (fetch_go),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .word_ok    (word_ok),
    .word       (word)
  );

  assign ir_op   = ir_q[OP_MSB:OP_LSB];
  assign word_op = word[OP_MSB:OP_LSB];
  assign in_exec = (state_q == EXEC);
  assign exec_b  = is_arit(ir_op) ? rf_db : imm_q;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    res_d    = res_q;
    flags_d  = flags_q;
    fetch_go = 1'b0;
    unique case (state_q)
      IDLE, HALT: if (start) state_d = FETCH;
      FETCH: begin
        if (word_ok) begin
          ir_d = word;
          if (word_op == OP_HALT)   state_d = HALT;
          else if (!is_arit(word_op)) state_d = FETCH_IMM;
          else                      state_d = EXEC;
        end
      end
      FETCH_IMM: begin
        if (word_ok) begin
          imm_d   = BITS'(word);
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d = ula_resu;
        // Constant ops leave the flag register untouched.
        if (is_arit(ir_op)) begin
          flags_d[FL_O] = ula_o;
          flags_d[FL_C] = ula_c;
          flags_d[FL_S] = ula_s;
          flags_d[FL_Z] = ula_z;
        end
        state_d = WB;
      end
      WB:      state_d = FETCH;
      default: state_d = IDLE;
    endcase
    fetch_go = (state_d == FETCH) || (state_d == FETCH_IMM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      imm_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      a_hold_q  <= '0;
      b_hold_q  <= '0;
      op_hold_q <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      rf_we_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      busy_q   <= (state_d != IDLE) && (state_d != HALT);
      halted_q <= (state_d == HALT);
      rf_we_q  <= (state_d == WB);
      if (in_exec) begin
        a_hold_q  <= rf_da;
        b_hold_q  <= exec_b;
        op_hold_q <= ir_op;
      end
    end
  end

  // Regfile reads are combinational, so the operand path is live only during EXEC.
  assign ula_a  = in_exec ? rf_da  : a_hold_q;
  assign ula_b  = in_exec ? exec_b : b_hold_q;
  assign ula_op = in_exec ? ir_op  : op_hold_q;

  assign rf_ra  = RF_AW'(ir_q[RD_MSB:RD_LSB]);
  assign rf_rb  = RF_AW'(ir_q[RB_MSB:RB_LSB]);
  assign rf_wa  = RF_AW'(ir_q[RD_MSB:RD_LSB]);
  assign rf_wd  = res_q;
  assign rf_we  = rf_we_q;
  assign busy   = busy_q;
  assign halted = halted_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Directed bench for ula_issue_ctrl with memory, regfile and ULA models.
// Expected writebacks are queued by the stimulus and popped by a writeback monitor.
module tb_ula_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, halted, imem_req, imem_valid, rf_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  rf_ra, rf_rb, rf_wa;
  logic [15:0] rf_da, rf_db, rf_wd, ula_a, ula_b, ula_resu;
  logic [7:0]  ula_op;
  logic        ula_o, ula_c, ula_s, ula_z;
  logic [3:0]  flags;

  typedef struct packed {
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  fl;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] mem [256];
  logic [15:0] rf  [16];
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic        force_valid = 1'b0;
  logic        pl_we = 1'b0;
  logic [3:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  always #5 clk = ~clk;

  ula_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_da(rf_da), .rf_db(rf_db),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_resu(ula_resu),
    .ula_o(ula_o), .ula_c(ula_c), .ula_s(ula_s), .ula_z(ula_z), .flags(flags)
  );

  // Memory answers after mem_lat cycles of an open request; force_valid injects junk.
  assign imem_valid = force_valid | (imem_req && (wait_cnt >= mem_lat));
  assign imem_rdata = mem[imem_addr];
  assign rf_da      = rf[rf_ra];
  assign rf_db      = rf[rf_rb];

  always @(posedge clk) begin
    if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
    if (pl_we)      rf[pl_a]  <= pl_d;
    else if (rf_we) rf[rf_wa] <= rf_wd;
  end

  // ULA model: op 0 add, 1 sub (C = borrow), 2 and, 3 or.
  always_comb begin
    logic [16:0] sum;
    sum      = 17'(ula_a) + 17'(ula_b);
    ula_resu = ula_a;
    ula_c    = 1'b0;
    ula_o    = 1'b0;
    case (ula_op[4:0])
      5'd0: begin
        ula_resu = sum[15:0];
        ula_c    = sum[16];
        ula_o    = (ula_a[15] == ula_b[15]) && (sum[15] != ula_a[15]);
      end
      5'd1: begin
        ula_resu = ula_a - ula_b;
        ula_c    = ula_a < ula_b;
        ula_o    = (ula_a[15] != ula_b[15]) && (ula_resu[15] != ula_a[15]);
      end
      5'd2:    ula_resu = ula_a & ula_b;
      5'd3:    ula_resu = ula_a | ula_b;
      default: ula_resu = ula_a;
    endcase
    ula_s = ula_resu[15];
    ula_z = (ula_resu == 16'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wb_wa", 32'(rf_wa), 32'(mon_e.wa));
        chk("wb_wd", 32'(rf_wd), 32'(mon_e.wd));
        chk("wb_flags", 32'(flags), 32'(mon_e.fl));
      end
    end
  end

  task automatic do_reset();
    start = 1'b0;
    force_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 16'hFF00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted();
    int k;
    k = 0;
    while (!halted && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    fill_halt();
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_pc", 32'(imem_addr), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_ula_op", 32'(ula_op), 0);
    chk("rst_ula_ab", 32'({ula_a, ula_b}), 0);

    // Reset lands mid-fetch while memory claims valid.
    mem[0] = 16'h8012;
    mem_lat = 5;
    @(negedge clk);
    pulse_start();
    chk("t1_req_open", 32'(imem_req), 1);
    @(negedge clk);
    rst_n = 1'b0;
    force_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t1_busy", 32'(busy), 0);
    chk("t1_req", 32'(imem_req), 0);
    chk("t1_pc", 32'(imem_addr), 0);
    chk("t1_flags", 32'(flags), 0);
    chk("t1_we", 32'(rf_we), 0);
    repeat (2) begin
      @(negedge clk);
      chk("t1_stale_busy", 32'(busy), 0);
      chk("t1_stale_pc", 32'(imem_addr), 0);
    end
    force_valid = 1'b0;

    // ADD r1,r2 with zero-wait memory; a start pulse during EXEC is ignored.
    do_reset();
    mem_lat = 0;
    fill_halt();
    mem[0] = 16'h8012;
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd7);
    exp_q.push_back('{wa: 4'd1, wd: 16'd12, fl: 4'b0000});
    @(negedge clk);
    pulse_start();
    chk("t2_fetch_req", 32'(imem_req), 1);
    chk("t2_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t2_ula_a", 32'(ula_a), 32'd5);
    chk("t2_ula_b", 32'(ula_b), 32'd7);
    chk("t2_ula_op", 32'(ula_op), 32'h80);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_we_cycle3", 32'(rf_we), 1);
    wait_halted();
    chk("t2_pc_after_halt", 32'(imem_addr), 32'd2);

    // Overflowing ADD, constant OR, then SUB x-x.
    do_reset();
    fill_halt();
    mem[0] = 16'h8012;
    mem[1] = 16'h4333;
    mem[2] = 16'h00F0;
    mem[3] = 16'h8122;
    preload(4'd1, 16'h7FFF);
    preload(4'd2, 16'h0001);
    preload(4'd3, 16'h000F);
    exp_q.push_back('{wa: 4'd1, wd: 16'h8000, fl: 4'b1010});
    exp_q.push_back('{wa: 4'd3, wd: 16'h00FF, fl: 4'b1010});
    exp_q.push_back('{wa: 4'd2, wd: 16'h0000, fl: 4'b0001});
    @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t3_fetch_addr", 32'(imem_addr), 32'd1);
    chk("t3_fetch_req", 32'(imem_req), 1);
    @(negedge clk);
    chk("t3_imm_addr", 32'(imem_addr), 32'd2);
    chk("t3_imm_req", 32'(imem_req), 1);
    @(negedge clk);
    chk("t3_ula_b_imm", 32'(ula_b), 32'h00F0);
    chk("t3_ula_op", 32'(ula_op), 32'h43);
    chk("t3_ula_a", 32'(ula_a), 32'h000F);
    @(negedge clk);
    chk("t3_ula_b_hold", 32'(ula_b), 32'h00F0);
    @(negedge clk);
    chk("t3_pc_after_wb", 32'(imem_addr), 32'd3);
    wait_halted();
    chk("t4_flags_final", 32'(flags), 32'b0001);
    chk("t4_pc_after_halt", 32'(imem_addr), 32'd5);

    // Slow memory: request and address hold through five wait cycles.
    do_reset();
    fill_halt();
    mem_lat = 5;
    mem[0] = 16'h8012;
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd7);
    exp_q.push_back('{wa: 4'd1, wd: 16'd12, fl: 4'b0000});
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      chk("t5_req_held", 32'(imem_req), 1);
      chk("t5_addr_held", 32'(imem_addr), 0);
      @(negedge clk);
    end
    start = 1'b0;
    wait_halted();
    chk("t5_pc_after_halt", 32'(imem_addr), 32'd2);
    mem_lat = 0;

    // PC wrap: HALT at 255, then a constant op whose immediate sits at address 0.
    do_reset();
    fill_halt();
    preload(4'd3, 16'h000F);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      pulse_start();
      wait_halted();
    end
    chk("t6_pc_255", 32'(imem_addr), 32'd255);
    @(negedge clk);
    pulse_start();
    wait_halted();
    chk("t6_pc_wrap", 32'(imem_addr), 32'd0);
    mem[255] = 16'h4333;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      pulse_start();
      wait_halted();
    end
    chk("t6_pc_255_again", 32'(imem_addr), 32'd255);
    exp_q.push_back('{wa: 4'd3, wd: 16'hFF0F, fl: 4'b0000});
    @(negedge clk);
    pulse_start();
    chk("t6_fetch_at_255", 32'(imem_addr), 32'd255);
    @(negedge clk);
    chk("t6_imm_at_0", 32'(imem_addr), 32'd0);
    wait_halted();
    chk("t6_pc_after_wrap_imm", 32'(imem_addr), 32'd2);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
